// File: rtl/clock_domain_export_arbiter_if.sv
// Request/export bundle for clock_domain_export_arbiter.
// CDC_EXPORT_ARB_TAG_EN widens exp_data by IDX_W to carry the source index in the MSBs.
interface clock_domain_export_arbiter_if #(
  parameter int N    = 4,
  parameter int SIZE = 8
);
  localparam int IDX_W  = $clog2(N);
`ifdef CDC_EXPORT_ARB_TAG_EN
  localparam int DATA_W = SIZE + IDX_W;
`else
  localparam int DATA_W = SIZE;
`endif

  logic [N*SIZE-1:0] req_data;
  logic [N-1:0]      req_stb;
  logic [N-1:0]      req_busy;
  logic [DATA_W-1:0] exp_data;
  logic              exp_stb;
  logic              exp_busy;
  logic [IDX_W-1:0]  grant_id;

  modport master (
    output req_data, req_stb, exp_busy,
    input  req_busy, exp_data, exp_stb, grant_id
  );

  modport slave (
    input  req_data, req_stb, exp_busy,
    output req_busy, exp_data, exp_stb, grant_id
  );
endinterface

// File: rtl/clock_domain_export_arbiter.sv
// Round-robin arbiter draining N one-entry request slots into one clock_domain_export channel.
// Optional macro CDC_EXPORT_ARB_TAG_EN: prefix exported payload with the source slot index.
module clock_domain_export_arbiter #(
  parameter int N    = 4,
  parameter int SIZE = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  clock_domain_export_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic [SIZE-1:0]  slot [N];
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic             any_busy;

  // First occupied slot searching from grant_id+1 around to grant_id itself.
  always_comb begin
    sel      = '0;
    cand     = '0;
    any_busy = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDX_W'((32'(bus.grant_id) + k) % N);
      if (!any_busy && bus.req_busy[cand]) begin
        sel      = cand;
        any_busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.req_busy <= '0;
      bus.exp_stb  <= 1'b0;
      bus.exp_data <= '0;
      bus.grant_id <= IDX_W'(N - 1);
      for (int unsigned i = 0; i < N; i++) slot[i] <= '0;
    end else begin
      // A slot being granted this edge is still busy, so its req_stb is dropped here.
      for (int unsigned i = 0; i < N; i++) begin
        if (bus.req_stb[i] && !bus.req_busy[i]) begin
          slot[i]         <= bus.req_data[i*SIZE +: SIZE];
          bus.req_busy[i] <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (any_busy && !bus.exp_busy) begin
            bus.exp_stb <= 1'b1;
`ifdef CDC_EXPORT_ARB_TAG_EN
            bus.exp_data <= {sel, slot[sel]};
`else
            bus.exp_data <= slot[sel];
`endif
            bus.grant_id      <= sel;
            bus.req_busy[sel] <= 1'b0;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          bus.exp_stb <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          if (!bus.exp_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clock_domain_export_arbiter.sv
// Directed bench for clock_domain_export_arbiter with a behavioural exporter busy model.
module tb_clock_domain_export_arbiter;
  localparam int N     = 4;
  localparam int SIZE  = 8;
  localparam int IDX_W = 2;
`ifdef CDC_EXPORT_ARB_TAG_EN
  localparam int DATA_W = SIZE + IDX_W;
`else
  localparam int DATA_W = SIZE;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clock_domain_export_arbiter_if #(.N(N), .SIZE(SIZE)) bus ();

  clock_domain_export_arbiter #(.N(N), .SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Exporter: busy rises the cycle after stb and lasts busy_len cycles; not reset by rst_n.
  int exp_cnt  = 0;
  int busy_len = 3;
  always @(posedge clk) begin
    if (bus.exp_stb) exp_cnt <= busy_len;
    else if (exp_cnt > 0) exp_cnt <= exp_cnt - 1;
  end
  assign bus.exp_busy = (exp_cnt != 0);

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [DATA_W-1:0] expd(input int id, input logic [7:0] d);
`ifdef CDC_EXPORT_ARB_TAG_EN
    return {2'(id), d};
`else
    return d;
`endif
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input int idx, input logic [7:0] d);
    bus.req_data[idx*SIZE +: SIZE] = d;
    bus.req_stb[idx] = 1'b1;
  endtask

  task automatic wait_for_stb(input int budget, output bit got);
    int n = 0;
    while (!bus.exp_stb && n < budget) begin
      step();
      n++;
    end
    got = bus.exp_stb;
  endtask

  task automatic drain();
    int n = 0;
    while (bus.exp_busy && n < 50) begin
      step();
      n++;
    end
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    vectors++;
    if (bus.req_busy !== 4'b0000) begin miscompares++; $display("FAIL reset_req_busy: got %b want 0000", bus.req_busy); end
    vectors++;
    if (bus.exp_stb !== 1'b0) begin miscompares++; $display("FAIL reset_exp_stb: got %b want 0", bus.exp_stb); end
    vectors++;
    if (bus.exp_data !== '0) begin miscompares++; $display("FAIL reset_exp_data: got %h want 0", bus.exp_data); end
    vectors++;
    if (bus.grant_id !== 2'd3) begin miscompares++; $display("FAIL reset_grant_id: got %0d want 3", bus.grant_id); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    busy_len = 3;
    load(2, 8'hA5);
    step();
    bus.req_stb = '0;
    vectors++;
    if (bus.req_busy !== 4'b0100) begin miscompares++; $display("FAIL single_busy: got %b want 0100", bus.req_busy); end
    vectors++;
    if (bus.exp_stb !== 1'b0) begin miscompares++; $display("FAIL single_early_stb: got %b want 0", bus.exp_stb); end
    step();
    vectors++;
    if (bus.exp_stb !== 1'b1) begin miscompares++; $display("FAIL single_stb: got %b want 1", bus.exp_stb); end
    vectors++;
    if (bus.exp_data !== expd(2, 8'hA5)) begin miscompares++; $display("FAIL single_data: got %h want %h", bus.exp_data, expd(2, 8'hA5)); end
    vectors++;
    if (bus.grant_id !== 2'd2) begin miscompares++; $display("FAIL single_grant: got %0d want 2", bus.grant_id); end
    vectors++;
    if (bus.req_busy !== 4'b0000) begin miscompares++; $display("FAIL single_busy_clr: got %b want 0000", bus.req_busy); end
    step();
    vectors++;
    if (bus.exp_stb !== 1'b0) begin miscompares++; $display("FAIL single_pulse: got %b want 0", bus.exp_stb); end
    vectors++;
    if (bus.exp_data !== expd(2, 8'hA5)) begin miscompares++; $display("FAIL single_hold: got %h want %h", bus.exp_data, expd(2, 8'hA5)); end
    drain();
  endtask

  task automatic test_round_robin();
    bit got;
    apply_reset();
    busy_len = 5;
    for (int i = 0; i < N; i++) load(i, 8'(8'h10 + i));
    step();
    bus.req_stb = '0;
    for (int j = 0; j < N; j++) begin
      wait_for_stb(40, got);
      vectors++;
      if (!got) begin miscompares++; $display("FAIL rr_timeout[%0d]: got no stb want stb", j); end
      vectors++;
      if (bus.grant_id !== 2'(j)) begin miscompares++; $display("FAIL rr_grant[%0d]: got %0d want %0d", j, bus.grant_id, j); end
      vectors++;
      if (bus.exp_data !== expd(j, 8'(8'h10 + j))) begin miscompares++; $display("FAIL rr_data[%0d]: got %h want %h", j, bus.exp_data, expd(j, 8'(8'h10 + j))); end
      step();
      vectors++;
      if (bus.exp_stb !== 1'b0) begin miscompares++; $display("FAIL rr_pulse[%0d]: got %b want 0", j, bus.exp_stb); end
    end
    drain();
  endtask

  task automatic test_drop();
    bit seen = 1'b0;
    load(1, 8'h22);
    step();
    vectors++;
    if (bus.req_busy[1] !== 1'b1) begin miscompares++; $display("FAIL drop_busy: got %b want 1", bus.req_busy[1]); end
    load(1, 8'h33);
    step();
    bus.req_stb = '0;
    vectors++;
    if (bus.exp_stb !== 1'b1) begin miscompares++; $display("FAIL drop_stb: got %b want 1", bus.exp_stb); end
    vectors++;
    if (bus.exp_data !== expd(1, 8'h22)) begin miscompares++; $display("FAIL drop_data: got %h want %h", bus.exp_data, expd(1, 8'h22)); end
    vectors++;
    if (bus.req_busy !== 4'b0000) begin miscompares++; $display("FAIL drop_slot_empty: got %b want 0000", bus.req_busy); end
    step();
    for (int i = 0; i < 15; i++) begin
      if (bus.exp_stb) seen = 1'b1;
      step();
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL drop_extra_stb: got %b want 0", seen); end
    drain();
  endtask

  task automatic test_tag();
    logic [DATA_W-1:0] want;
`ifdef CDC_EXPORT_ARB_TAG_EN
    want = 10'b11_0111_1110;
`else
    want = 8'h7E;
`endif
    busy_len = 5;
    load(3, 8'h7E);
    step();
    bus.req_stb = '0;
    step();
    vectors++;
    if (bus.exp_stb !== 1'b1) begin miscompares++; $display("FAIL tag_stb: got %b want 1", bus.exp_stb); end
    vectors++;
    if (bus.exp_data !== want) begin miscompares++; $display("FAIL tag_data: got %h want %h", bus.exp_data, want); end
    vectors++;
    if (bus.grant_id !== 2'd3) begin miscompares++; $display("FAIL tag_grant: got %0d want 3", bus.grant_id); end
  endtask

  task automatic test_wrap();
    bit got;
    load(0, 8'h40);
    load(3, 8'h43);
    step();
    bus.req_stb = '0;
    vectors++;
    if (bus.req_busy !== 4'b1001) begin miscompares++; $display("FAIL wrap_busy: got %b want 1001", bus.req_busy); end
    wait_for_stb(40, got);
    vectors++;
    if (!got || bus.grant_id !== 2'd0 || bus.exp_data !== expd(0, 8'h40)) begin
      miscompares++; $display("FAIL wrap_first: got stb=%b id=%0d data=%h want stb=1 id=0 data=%h", got, bus.grant_id, bus.exp_data, expd(0, 8'h40));
    end
    step();
    wait_for_stb(40, got);
    vectors++;
    if (!got || bus.grant_id !== 2'd3 || bus.exp_data !== expd(3, 8'h43)) begin
      miscompares++; $display("FAIL wrap_second: got stb=%b id=%0d data=%h want stb=1 id=3 data=%h", got, bus.grant_id, bus.exp_data, expd(3, 8'h43));
    end
    step();
    drain();
  endtask

  task automatic test_reset_mid_wait();
    bit got;
    int n = 0;
    busy_len = 12;
    load(0, 8'h01);
    load(1, 8'h02);
    load(2, 8'h03);
    step();
    bus.req_stb = '0;
    wait_for_stb(20, got);
    vectors++;
    if (!got || bus.grant_id !== 2'd0) begin miscompares++; $display("FAIL rst_pre_issue: got stb=%b id=%0d want stb=1 id=0", got, bus.grant_id); end
    step();
    load(3, 8'h04);
    step();
    bus.req_stb = '0;
    vectors++;
    if (bus.req_busy !== 4'b1110) begin miscompares++; $display("FAIL rst_pre_busy: got %b want 1110", bus.req_busy); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.req_busy !== 4'b0000) begin miscompares++; $display("FAIL rst_async_busy: got %b want 0000", bus.req_busy); end
    vectors++;
    if (bus.exp_stb !== 1'b0) begin miscompares++; $display("FAIL rst_async_stb: got %b want 0", bus.exp_stb); end
    vectors++;
    if (bus.grant_id !== 2'd3) begin miscompares++; $display("FAIL rst_async_grant: got %0d want 3", bus.grant_id); end
    step();
    rst_n = 1'b1;
    load(2, 8'h55);
    step();
    bus.req_stb = '0;
    while (bus.exp_busy && n < 30) begin
      vectors++;
      if (bus.exp_stb !== 1'b0) begin miscompares++; $display("FAIL rst_wait_busy: got stb=%b want 0 while exporter busy", bus.exp_stb); end
      step();
      n++;
    end
    wait_for_stb(10, got);
    vectors++;
    if (!got || bus.grant_id !== 2'd2 || bus.exp_data !== expd(2, 8'h55)) begin
      miscompares++; $display("FAIL rst_post_issue: got stb=%b id=%0d data=%h want stb=1 id=2 data=%h", got, bus.grant_id, bus.exp_data, expd(2, 8'h55));
    end
    step();
    drain();
  endtask

  initial begin
    bus.req_data = '0;
    bus.req_stb  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_tag();
    test_wrap();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end
endmodule
